// File: rtl/bp_be_pipe_int_arb.sv
// Round-robin issue arbiter (dispatch vs replay) in front of the integer pipe, with a one-entry result register.
// Latency: 1 cycle issue-to-result. Backpressure: res_ready_i=0 holds the result and blocks every grant.
module bp_be_pipe_int_arb #(
    parameter int vaddr_width_p = 39,
    parameter int dword_width_p = 64,
    parameter int pkt_width_p   = 256
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [1:0]                 req_v_i,
    input  logic [2*pkt_width_p-1:0]   req_pkt_i,
    output logic [1:0]                 req_ready_o,
    output logic                       pipe_v_o,
    output logic [pkt_width_p-1:0]     pipe_pkt_o,
    input  logic [dword_width_p-1:0]   pipe_data_i,
    input  logic [vaddr_width_p-1:0]   pipe_br_tgt_i,
    output logic                       res_v_o,
    output logic                       res_id_o,
    output logic [dword_width_p-1:0]   res_data_o,
    output logic [vaddr_width_p-1:0]   res_br_tgt_o,
    input  logic                       res_ready_i,
    input  logic                       flush_i
);

    typedef enum logic {
        E_EMPTY = 1'b0,
        E_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic                     id;
        logic [dword_width_p-1:0] data;
        logic [vaddr_width_p-1:0] br_tgt;
    } res_t;

    state_e     state_q, state_d;
    res_t       res_q, res_d;
    logic       last_grant_q, last_grant_d;
    logic       issue_ok;
    logic       grant_id;
    logic [1:0] grant_oh;
    logic       hs;
    logic [pkt_width_p-1:0] pipe_pkt;

    // Grant is built only from req_v_i and local state, never from the other requester's ready.
    always_comb begin
        issue_ok = ((state_q == E_EMPTY) || res_ready_i) && !flush_i && !reset_i;
        grant_id = 1'b0;
        case (req_v_i)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant_q;
            default: grant_id = 1'b0;
        endcase
        grant_oh = 2'b00;
        if (issue_ok && (req_v_i != 2'b00)) begin
            grant_oh = grant_id ? 2'b10 : 2'b01;
        end
        hs = |grant_oh;
        pipe_pkt = '0;
        if (hs) begin
            pipe_pkt = grant_id ? req_pkt_i[2*pkt_width_p-1:pkt_width_p]
                                : req_pkt_i[pkt_width_p-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        last_grant_d = last_grant_q;
        if (flush_i) begin
            state_d = E_EMPTY;
        end else if (hs) begin
            state_d      = E_FULL;
            res_d.id     = grant_id;
            res_d.data   = pipe_data_i;
            res_d.br_tgt = pipe_br_tgt_i;
            last_grant_d = grant_id;
        end else if ((state_q == E_FULL) && res_ready_i) begin
            state_d = E_EMPTY;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= E_EMPTY;
            res_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_ready_o  = grant_oh;
    assign pipe_v_o     = hs;
    assign pipe_pkt_o   = pipe_pkt;
    assign res_v_o      = (state_q == E_FULL);
    assign res_id_o     = res_q.id;
    assign res_data_o   = res_q.data;
    assign res_br_tgt_o = res_q.br_tgt;

endmodule

// File: tb/tb_bp_be_pipe_int_arb.sv
// Vector table plus result scoreboard for the integer-pipe issue arbiter.
module tb_bp_be_pipe_int_arb;

    localparam int VW = 39;
    localparam int DW = 64;
    localparam int PW = 256;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [1:0]      req_v_i;
    logic [2*PW-1:0] req_pkt_i;
    logic [1:0]      req_ready_o;
    logic            pipe_v_o;
    logic [PW-1:0]   pipe_pkt_o;
    logic [DW-1:0]   pipe_data_i;
    logic [VW-1:0]   pipe_br_tgt_i;
    logic            res_v_o;
    logic            res_id_o;
    logic [DW-1:0]   res_data_o;
    logic [VW-1:0]   res_br_tgt_o;
    logic            res_ready_i;
    logic            flush_i;

    bp_be_pipe_int_arb #(
        .vaddr_width_p(VW),
        .dword_width_p(DW),
        .pkt_width_p  (PW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_v_i      (req_v_i),
        .req_pkt_i    (req_pkt_i),
        .req_ready_o  (req_ready_o),
        .pipe_v_o     (pipe_v_o),
        .pipe_pkt_o   (pipe_pkt_o),
        .pipe_data_i  (pipe_data_i),
        .pipe_br_tgt_i(pipe_br_tgt_i),
        .res_v_o      (res_v_o),
        .res_id_o     (res_id_o),
        .res_data_o   (res_data_o),
        .res_br_tgt_o (res_br_tgt_o),
        .res_ready_i  (res_ready_i),
        .flush_i      (flush_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  req_v;
        logic        rdy;
        logic        fl;
        logic [63:0] data;
        logic [1:0]  exp_ready;
        logic        exp_rv;
    } vec_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        logic [VW-1:0] tgt;
    } sb_t;

    int   total = 0;
    int   bad   = 0;
    sb_t  sb_q[$];
    vec_t tbl[22];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] tgt_of(input logic [63:0] d);
        tgt_of = VW'(d * 3) ^ 39'h12_3456_789A;
    endfunction

    // Drive one cycle of inputs at posedge+1, check at the following negedge.
    task automatic apply(input vec_t v, input int tag);
        logic [PW-1:0] pkt0, pkt1, exp_pkt;
        sb_t           e, n;
        pkt0 = {232'h0, 8'(tag), 8'hC0, 8'hD0};
        pkt1 = {232'h0, 8'(tag), 8'hC1, 8'hD1};
        req_v_i       = v.req_v;
        res_ready_i   = v.rdy;
        flush_i       = v.fl;
        pipe_data_i   = v.data;
        pipe_br_tgt_i = tgt_of(v.data);
        req_pkt_i     = {pkt1, pkt0};
        @(negedge clk_i);
        exp_pkt = (v.exp_ready == 2'b01) ? pkt0 : (v.exp_ready == 2'b10) ? pkt1 : '0;
        chk($sformatf("req_ready[%0d]", tag), PW'(req_ready_o), PW'(v.exp_ready));
        chk($sformatf("pipe_v[%0d]", tag), PW'(pipe_v_o), PW'(v.exp_ready != 2'b00));
        chk($sformatf("pipe_pkt[%0d]", tag), pipe_pkt_o, exp_pkt);
        chk($sformatf("res_v[%0d]", tag), PW'(res_v_o), PW'(v.exp_rv));
        if (v.exp_rv) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow[%0d]: got res_v_o=%0b required a queued result", tag, res_v_o);
            end else begin
                e = sb_q[0];
                chk($sformatf("res_id[%0d]", tag), PW'(res_id_o), PW'(e.id));
                chk($sformatf("res_data[%0d]", tag), PW'(res_data_o), PW'(e.data));
                chk($sformatf("res_tgt[%0d]", tag), PW'(res_br_tgt_o), PW'(e.tgt));
                if (v.rdy || v.fl) void'(sb_q.pop_front());
            end
        end
        if (v.exp_ready != 2'b00) begin
            n.id   = v.exp_ready[1];
            n.data = v.data;
            n.tgt  = tgt_of(v.data);
            sb_q.push_back(n);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // req_v, rdy, flush, pipe_data, expected req_ready, expected res_v
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 64'h11, 2'b01, 1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 64'h22, 2'b10, 1'b1};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 64'h33, 2'b01, 1'b1};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 64'h44, 2'b10, 1'b1};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 64'h55, 2'b01, 1'b1};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 64'h66, 2'b10, 1'b1};
        tbl[6]  = '{2'b01, 1'b0, 1'b0, 64'hA1, 2'b00, 1'b1};
        tbl[7]  = '{2'b01, 1'b0, 1'b0, 64'hA2, 2'b00, 1'b1};
        tbl[8]  = '{2'b01, 1'b0, 1'b0, 64'hA3, 2'b00, 1'b1};
        tbl[9]  = '{2'b01, 1'b1, 1'b0, 64'hB0, 2'b01, 1'b1};
        tbl[10] = '{2'b10, 1'b0, 1'b1, 64'hBAD, 2'b00, 1'b1};
        tbl[11] = '{2'b10, 1'b1, 1'b0, 64'hC1, 2'b10, 1'b0};
        tbl[12] = '{2'b10, 1'b1, 1'b0, 64'hC2, 2'b10, 1'b1};
        tbl[13] = '{2'b10, 1'b1, 1'b0, 64'hC3, 2'b10, 1'b1};
        tbl[14] = '{2'b10, 1'b1, 1'b0, 64'hC4, 2'b10, 1'b1};
        tbl[15] = '{2'b00, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1};
        tbl[16] = '{2'b00, 1'b1, 1'b0, 64'h0, 2'b00, 1'b0};
        tbl[17] = '{2'b11, 1'b0, 1'b0, 64'hD1, 2'b01, 1'b0};
        tbl[18] = '{2'b11, 1'b0, 1'b0, 64'hD2, 2'b00, 1'b1};
        tbl[19] = '{2'b10, 1'b1, 1'b1, 64'hD3, 2'b00, 1'b1};
        tbl[20] = '{2'b11, 1'b1, 1'b0, 64'hE1, 2'b10, 1'b0};
        tbl[21] = '{2'b00, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1};

        reset_i       = 1'b1;
        req_v_i       = 2'b11;
        req_pkt_i     = {2*PW{1'b1}};
        res_ready_i   = 1'b1;
        flush_i       = 1'b0;
        pipe_data_i   = 64'hFFFF;
        pipe_br_tgt_i = '1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", PW'(req_ready_o), PW'(2'b00));
        chk("rst_pipe_v", PW'(pipe_v_o), PW'(1'b0));
        chk("rst_res_v", PW'(res_v_o), PW'(1'b0));
        chk("rst_res_data", PW'(res_data_o), PW'(0));
        chk("rst_res_tgt", PW'(res_br_tgt_o), PW'(0));
        chk("rst_res_id", PW'(res_id_o), PW'(0));
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], i);
        end

        // Fill the result register with last_grant=0, then reset mid-cycle.
        apply('{2'b01, 1'b0, 1'b0, 64'h77, 2'b01, 1'b0}, 30);
        req_v_i     = 2'b11;
        res_ready_i = 1'b0;
        #1;
        chk("pre_rst_res_v", PW'(res_v_o), PW'(1'b1));
        reset_i = 1'b1;
        #1;
        chk("mid_rst_res_v", PW'(res_v_o), PW'(1'b0));
        chk("mid_rst_res_data", PW'(res_data_o), PW'(0));
        chk("mid_rst_req_ready", PW'(req_ready_o), PW'(2'b00));
        chk("mid_rst_pipe_v", PW'(pipe_v_o), PW'(1'b0));
        sb_q.delete();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        apply('{2'b11, 1'b1, 1'b0, 64'h99, 2'b01, 1'b0}, 31);
        apply('{2'b00, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1}, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
